// File: rtl/example_counter.sv
// Programmable-modulo up-counter: counts 0..L per period, L captured from dIN at period start.
// Optional wrap counter output enabled by defining EXAMPLE_COUNTER_WRAP_CNT_EN.
module example_counter #(
  parameter int bit_width = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clk_en,
  input  logic [bit_width-1:0] dIN,
  output logic [bit_width-1:0] dOUT,
  output logic                 tc
`ifdef EXAMPLE_COUNTER_WRAP_CNT_EN
  ,
  output logic [bit_width-1:0] wrap_cnt
`endif
);

  localparam logic [bit_width-1:0] ZERO = '0;
  localparam logic [bit_width-1:0] ONES = '1;
  localparam logic [bit_width-1:0] ONE  = bit_width'(1);

  logic [bit_width-1:0] cnt_q, cnt_d;
  logic [bit_width-1:0] limit_q, limit_d;
  logic [bit_width-1:0] eff_s;
  logic                 tc_q, tc_d;

  // Next-state: at count zero the live dIN is the limit, otherwise the captured one.
  always_comb begin
    cnt_d   = cnt_q;
    limit_d = limit_q;
    tc_d    = 1'b0;
    if (cnt_q == ZERO) begin
      eff_s = dIN;
    end else begin
      eff_s = limit_q;
    end
    if (clk_en) begin
      if (cnt_q == ZERO) begin
        limit_d = dIN;
      end else begin
        limit_d = limit_q;
      end
      // >= so an out-of-range count wraps immediately instead of running to all-ones
      if (cnt_q >= eff_s) begin
        cnt_d = ZERO;
        tc_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + ONE;
        tc_d  = 1'b0;
      end
    end else begin
      cnt_d   = cnt_q;
      limit_d = limit_q;
      tc_d    = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= ZERO;
      limit_q <= ONES;
      tc_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      limit_q <= limit_d;
      tc_q    <= tc_d;
    end
  end

  assign dOUT = cnt_q;
  assign tc   = tc_q;

`ifdef EXAMPLE_COUNTER_WRAP_CNT_EN
  logic [bit_width-1:0] wrap_cnt_q, wrap_cnt_d;

  // Saturating count of wraps; tc_d is exactly the wrap condition.
  always_comb begin
    wrap_cnt_d = wrap_cnt_q;
    if (tc_d && (wrap_cnt_q != ONES)) begin
      wrap_cnt_d = wrap_cnt_q + ONE;
    end else begin
      wrap_cnt_d = wrap_cnt_q;
    end
  end

  // Wrap counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrap_cnt_q <= ZERO;
    end else begin
      wrap_cnt_q <= wrap_cnt_d;
    end
  end

  assign wrap_cnt = wrap_cnt_q;
`endif

endmodule

// File: tb/tb_example_counter.sv
// Directed self-checking bench for example_counter at bit_width=5.
// Wrap-counter checks are active when EXAMPLE_COUNTER_WRAP_CNT_EN is defined.
module tb_example_counter;

  logic       clk;
  logic       rst;
  logic       clk_en;
  logic [4:0] dIN;
  logic [4:0] dOUT;
  logic       tc;
`ifdef EXAMPLE_COUNTER_WRAP_CNT_EN
  logic [4:0] wrap_cnt;
  int         exp_wraps;
`endif

  int errors;
  int checks;

  example_counter #(.bit_width(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .clk_en   (clk_en),
    .dIN      (dIN),
    .dOUT     (dOUT),
    .tc       (tc)
`ifdef EXAMPLE_COUNTER_WRAP_CNT_EN
    ,
    .wrap_cnt (wrap_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock edge, then compare count and tc (and the wrap counter model if present).
  task automatic tick(input string tag, input int exp_d, input logic exp_tc);
    @(posedge clk);
    #1;
    check({tag, ".dOUT"}, 32'(dOUT), 32'(exp_d));
    check({tag, ".tc"}, 32'(tc), 32'(exp_tc));
`ifdef EXAMPLE_COUNTER_WRAP_CNT_EN
    if (exp_tc && (exp_wraps < 31)) exp_wraps++;
    check({tag, ".wrap_cnt"}, 32'(wrap_cnt), 32'(exp_wraps));
`endif
  endtask

  initial begin
    int k;
    int exp_seq[8];
    errors = 0;
    checks = 0;
`ifdef EXAMPLE_COUNTER_WRAP_CNT_EN
    exp_wraps = 0;
`endif
    rst    = 1'b1;
    clk_en = 1'b0;
    dIN    = 5'd3;

    // Asynchronous reset with no clock edge
    #1 rst = 1'b0;
    #1;
    check("rst_async.dOUT", 32'(dOUT), 32'd0);
    check("rst_async.tc", 32'(tc), 32'd0);

    // Held in reset despite clk_en
    clk_en = 1'b1;
    for (int i = 0; i < 3; i++) tick("rst_hold", 0, 1'b0);

    // Basic wrap with dIN=3
    rst = 1'b1;
    exp_seq = '{1, 2, 3, 0, 1, 2, 3, 0};
    for (int i = 0; i < 8; i++) tick("basic", exp_seq[i], (exp_seq[i] == 0));

    // Enable gating: 1,0,1,0,...
    for (int i = 0; i < 8; i++) begin
      clk_en = (i % 2 == 0) ? 1'b1 : 1'b0;
      k = (i / 2 + 1) % 4;
      tick("gate", k, (i == 6));
    end

    // Limit change mid-period is ignored until next period
    clk_en = 1'b1;
    dIN    = 5'd3;
    tick("lim_a", 1, 1'b0);
    tick("lim_a", 2, 1'b0);
    dIN = 5'd6;
    tick("lim_a", 3, 1'b0);
    tick("lim_a", 0, 1'b1);
    for (int i = 1; i <= 6; i++) tick("lim_b", i, 1'b0);
    tick("lim_b", 0, 1'b1);
    dIN = 5'd2;
    tick("lim_c", 1, 1'b0);
    tick("lim_c", 2, 1'b0);
    tick("lim_c", 0, 1'b1);

    // dIN=0: period of one, tc on every enabled edge only
    dIN = 5'd0;
    for (int i = 0; i < 4; i++) tick("zero", 0, 1'b1);
    clk_en = 1'b0;
    tick("zero_dis", 0, 1'b0);
    clk_en = 1'b1;

    // dIN=31: full range, single tc per 32 edges
    dIN = 5'd31;
    for (int i = 1; i <= 31; i++) tick("full", i, 1'b0);
    tick("full", 0, 1'b1);
    tick("full_after", 1, 1'b0);
    tick("full_after", 2, 1'b0);
    tick("full_after", 3, 1'b0);
    tick("full_after", 4, 1'b0);
    tick("full_after", 5, 1'b0);
    tick("full_after", 6, 1'b0);
    tick("full_after", 7, 1'b0);

    // Mid-run reset at dOUT=7, applied between edges
    #2 rst = 1'b0;
    #1;
    check("rst_mid.dOUT", 32'(dOUT), 32'd0);
    check("rst_mid.tc", 32'(tc), 32'd0);
`ifdef EXAMPLE_COUNTER_WRAP_CNT_EN
    exp_wraps = 0;
    check("rst_mid.wrap_cnt", 32'(wrap_cnt), 32'd0);
`endif
    tick("rst_mid_hold", 0, 1'b0);
    tick("rst_mid_hold", 0, 1'b0);
    rst = 1'b1;
    dIN = 5'd2;
    tick("post_rst", 1, 1'b0);
    tick("post_rst", 2, 1'b0);
    tick("post_rst", 0, 1'b1);

`ifdef EXAMPLE_COUNTER_WRAP_CNT_EN
    // Three wraps then reset clears wrap_cnt
    dIN = 5'd0;
    tick("wc3", 0, 1'b1);
    tick("wc3", 0, 1'b1);
    #2 rst = 1'b0;
    #1;
    exp_wraps = 0;
    check("wc_rst.wrap_cnt", 32'(wrap_cnt), 32'd0);
    check("wc_rst.dOUT", 32'(dOUT), 32'd0);
    rst = 1'b1;
    // Saturation at 31 with dIN=31 over 33 periods
    dIN = 5'd31;
    for (int p = 0; p < 33; p++) begin
      for (int i = 1; i <= 31; i++) tick("sat", i, 1'b0);
      tick("sat", 0, 1'b1);
    end
    check("sat.final", 32'(wrap_cnt), 32'd31);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/example_counter.md
Name: example_counter

Overview:
- Programmable-modulo up-counter with clock enable, parameterised by bit_width.
- Each period counts 0..L on enabled clock edges, then wraps to 0, so one period is L+1 enabled edges.
- The limit L is sampled from dIN at the start of each period.
- Used as a generic tick/period generator; dOUT is the running count and tc flags every wrap.

Parameters:
- bit_width, 8, width of dIN, dOUT and the internal limit register (minimum 1).

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted, 1 = run).
- clk_en  input  1  count enable, sampled on rising clk; 0 = counter state holds.
- dIN  input  bit_width  requested terminal value L (unsigned).
- dOUT  output  bit_width  current count, registered.
- tc  output  1  terminal-count pulse, registered.

Behaviour:
- Reset (rst=0, asynchronous, no clock needed): dOUT=0, tc=0, limit_q=all-ones. Reset takes effect immediately and overrides clk_en.
- Effective limit: eff = (dOUT==0) ? dIN : limit_q. The limit is captured at the start of each period.
- On a rising clk with clk_en=1:
  - If dOUT==0, then limit_q <= dIN.
  - If dOUT >= eff, then dOUT <= 0 and tc <= 1 (wrap).
  - Otherwise dOUT <= dOUT+1 and tc <= 0.
- On a rising clk with clk_en=0: dOUT and limit_q hold; tc <= 0.
- tc is high for exactly one clk cycle, the cycle after the wrapping edge, regardless of the clk_en duty cycle.
- Latency: a change on dIN affects counting only when dOUT==0, i.e. at the next period start.
- Mid-period dIN changes are ignored; the current period completes against limit_q.
- dIN==0: dOUT stays 0, and tc pulses on every enabled edge (period of 1).
- dIN==all-ones: counts 0..2^bit_width-1 then wraps to 0. No carry-out or overflow state; the increment never exceeds the width.
- The comparison is >=, not ==. If the count is ever above eff, it wraps on the next enabled edge rather than running through all-ones.
- Reset mid-operation: the count is lost, and the next period uses the dIN value present at the first enabled edge after rst deasserts.
- rst deassertion is synchronised externally. The block only requires rst to be stable around the clk edge.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: EXAMPLE_COUNTER_WRAP_CNT_EN.
- Defined: adds output port wrap_cnt [bit_width]. It increments on every enabled edge that wraps (same condition that sets tc) and saturates at all-ones. It resets to 0 on rst=0.
- Undefined: the wrap_cnt port and its register are absent, and all other behaviour is identical.

Test Plan (all with bit_width=5):
- Reset: dOUT=7, drive rst=0 between clock edges → dOUT=0 and tc=0 at once with no clk edge; held while rst=0 despite clk_en=1.
- Basic wrap: rst=1, clk_en=1, dIN=3 → dOUT sequence 0,1,2,3,0,1,2,3,0; tc=1 only in each cycle after 3→0.
- Enable gating: clk_en toggling 1,0,1,0, dIN=3 → dOUT changes only on edges with clk_en=1 (0,0,1,1,2,2,3,3,0); tc high for 1 clk, not 2.
- Limit change: dIN=3, change dIN to 6 while dOUT=2 → wraps after 3, then counts 0..6, wraps; change to 2 at dOUT=0 takes effect that period.
- Boundaries: dIN=0 → dOUT stays 0, tc=1 after every enabled edge. dIN=31 → 0..31 then 0, with a single tc pulse per 32 enabled edges.
- Mid-run reset with the option defined: let 3 wraps occur (wrap_cnt=3), pulse rst=0 → wrap_cnt=0, dOUT=0. With dIN=31, run >31 wraps → wrap_cnt saturates at 31.
